// File: rtl/keyed_lut_lock_array.sv
// keyed_lut_lock_array: NUM_CELLS key-programmable 2-input LUT cells.
// The key arrives serially on a frame of KEY_W data bits followed by one even-parity bit.
// A frame is verified on commit. Repeated bad commits end in a permanent lockout, which only rst clears.
// Each cell output is registered, so the datapath has a latency of one cycle.
module keyed_lut_lock_array #(
  parameter int NUM_CELLS = 6,
  parameter int MAX_FAIL  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_in_valid,
  output logic                 key_in_ready,
  input  logic                 key_in_bit,
  input  logic                 key_commit,
  input  logic                 in_valid,
  input  logic [NUM_CELLS-1:0] a_in,
  input  logic [NUM_CELLS-1:0] b_in,
  output logic [NUM_CELLS-1:0] y_out,
  output logic                 out_valid,
  output logic                 key_active,
  output logic                 key_locked,
  output logic [3:0]           fail_cnt
);

  localparam int KEY_W   = 4 * NUM_CELLS;
  localparam int FRAME_W = KEY_W + 1;
  localparam int CNT_W   = $clog2(KEY_W + 3);
  // The bit count reaches CNT_FULL after a complete frame.
  // It reaches CNT_OVF once a surplus bit has been seen.
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_OVF    = CNT_W'(FRAME_W + 1);
  localparam logic [3:0]       FAIL_LIMIT = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_ACTIVE,
    S_LOCKOUT
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [KEY_W:0]        r_shadow;
  logic [CNT_W-1:0]      r_cnt;
  logic [KEY_W-1:0]      r_key;
  logic                  r_key_active;
  logic [3:0]            r_fail_cnt;
  logic [NUM_CELLS-1:0]  r_y;
  logic                  r_out_valid;

  logic                  w_commit;
  logic                  w_accept;
  logic                  w_ovf;
  logic                  w_pass;
  logic [3:0]            w_fail_next;
  logic                  w_lock;
  logic                  w_run;
  logic [NUM_CELLS-1:0]  w_y;

  assign key_in_ready = (r_state == S_IDLE) || (r_state == S_SHIFT) || (r_state == S_ACTIVE);

  // A commit inside a frame takes priority over a bit arriving in the same cycle.
  assign w_commit    = key_commit && (r_state == S_SHIFT);
  assign w_accept    = key_in_valid && key_in_ready && !w_commit;
  assign w_ovf       = (r_cnt == CNT_OVF);
  assign w_pass      = (r_cnt == CNT_FULL) && !w_ovf && !(^r_shadow);
  assign w_fail_next = r_fail_cnt + 4'd1;
  assign w_lock      = (w_fail_next == FAIL_LIMIT);

  // State register.
  // NOTE: every clocked block uses non-blocking assignments.
  // All registers therefore update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode for the key loader.
  // NOTE: w_state_next is assigned a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_ACTIVE: if (w_accept) w_state_next = S_SHIFT;
      S_SHIFT:          if (w_commit) w_state_next = S_CHECK;
      S_CHECK: begin
        if (w_pass)            w_state_next = S_ACTIVE;
        else if (w_lock)       w_state_next = S_LOCKOUT;
        else if (r_key_active) w_state_next = S_ACTIVE;
        else                   w_state_next = S_IDLE;
      end
      S_LOCKOUT:        w_state_next = S_LOCKOUT;
      default:          w_state_next = S_IDLE;
    endcase
  end

  // Shadow shift register and frame bit counter.
  // Surplus bits are dropped; the count saturates to flag the overflow.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_CHECK) begin
      r_shadow <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      if (r_cnt < CNT_FULL) r_shadow <= {r_shadow[KEY_W-1:0], key_in_bit};
      if (r_cnt != CNT_OVF) r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Verdict of the CHECK cycle: install the key, or count the failure and maybe lock out.
  // NOTE: the key store is explicitly reset, so no stale key is usable after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key        <= '0;
      r_key_active <= 1'b0;
      r_fail_cnt   <= 4'd0;
    end else if (r_state == S_CHECK) begin
      if (w_pass) begin
        r_key        <= r_shadow[KEY_W:1];
        r_key_active <= 1'b1;
        r_fail_cnt   <= 4'd0;
      end else begin
        r_fail_cnt <= w_fail_next;
        if (w_lock) begin
          r_key        <= '0;
          r_key_active <= 1'b0;
        end
      end
    end
  end

  // Each cell is a 4-entry LUT slice of the key, addressed by {a, b}.
  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
    logic [3:0] w_lut;
    assign w_lut  = r_key[4*g +: 4];
    assign w_y[g] = w_lut[{a_in[g], b_in[g]}];
  end

  // The datapath runs on a verified key, and the old key keeps running during a reload.
  assign w_run = ((r_state == S_ACTIVE) ||
                  (((r_state == S_SHIFT) || (r_state == S_CHECK)) && r_key_active)) &&
                 (w_state_next != S_LOCKOUT);

  // Registered cell outputs.
  // y_out holds while idle and is forced to zero when no key is running.
  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_y         <= w_y;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign y_out      = r_y;
  assign out_valid  = r_out_valid;
  assign key_active = r_key_active;
  assign key_locked = (r_state == S_LOCKOUT);
  assign fail_cnt   = r_fail_cnt;

endmodule
